rx_phase_cycler: RTL and testbench

- Scan-level sequencer for the receiver phase-rotation stage (2-bit phase select: 0/90/180/270 deg).
- Steps the receiver phase through a programmable phase-cycling table, one entry per scan (e.g. CYCLOPS).
- Opens an acquisition window of programmable length after each trigger and counts scans.
- Holds the phase constant for the whole window, so the combinational rotator never switches mid-acquisition.

---
 rtl/rx_pkg.sv | 20 ++
 rtl/rx_phase_table.sv | 31 +++
 rtl/rx_phase_cycler.sv | 172 +++++++++++++++++
 tb/tb_rx_phase_cycler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared phase encoding, sequencer states and table depth for the receiver phase path.
package rx_pkg;

    localparam int TBL_DEPTH_DEF = 8;

    // Rotator phase select encoding; the rotator decodes the same values.
    localparam logic [1:0] PH_0   = 2'd0;
    localparam logic [1:0] PH_90  = 2'd1;
    localparam logic [1:0] PH_180 = 2'd2;
    localparam logic [1:0] PH_270 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_ACQ  = 3'd2,
        ST_NEXT = 3'd3,
        ST_FIN  = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_phase_table.sv
// rtl/rx_phase_table.sv - phase-cycling table: synchronous write, asynchronous read.
module rx_phase_table
    import rx_pkg::*;
#(
    parameter int TBL_DEPTH = TBL_DEPTH_DEF,
    parameter int TBL_AW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [TBL_AW-1:0] waddr_i,
    input  logic [1:0]        wdata_i,
    input  logic [TBL_AW-1:0] raddr_i,
    output logic [1:0]        rdata_o
);

    logic [1:0] mem_q [TBL_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                mem_q[i] <= PH_0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_phase_cycler.sv
// rtl/rx_phase_cycler.sv - scan sequencer: steps the rotator phase per scan and gates acquisition windows.
module rx_phase_cycler
    import rx_pkg::*;
#(
    parameter int TBL_DEPTH = TBL_DEPTH_DEF,
    parameter int TBL_AW    = 3,
    parameter int SCAN_W    = 16,
    parameter int ACQ_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [TBL_AW-1:0] cfg_addr,
    input  logic [1:0]        cfg_phase,
    input  logic [TBL_AW:0]   cfg_tbl_len,
    input  logic [SCAN_W-1:0] cfg_n_scans,
    input  logic [ACQ_W-1:0]  cfg_acq_len,
    input  logic              start,
    input  logic              abort,
    input  logic              trig,
    output logic [1:0]        phase,
    output logic              acq_valid,
    output logic [SCAN_W-1:0] scan_count,
    output logic              busy,
    output logic              done,
    output logic              err_trig
);

    localparam logic [TBL_AW:0]   LEN_ONE  = (TBL_AW+1)'(1);
    localparam logic [TBL_AW:0]   LEN_MAX  = (TBL_AW+1)'(TBL_DEPTH);
    localparam logic [TBL_AW-1:0] IDX_ONE  = TBL_AW'(1);
    localparam logic [SCAN_W-1:0] SCAN_ONE = SCAN_W'(1);
    localparam logic [ACQ_W-1:0]  ACQ_ONE  = ACQ_W'(1);

    rx_state_e         state_q, state_d;
    logic [TBL_AW-1:0] idx_q, idx_d;
    logic [TBL_AW:0]   tbl_len_q, tbl_len_d;
    logic [SCAN_W-1:0] n_scans_q, n_scans_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [ACQ_W-1:0]  acq_len_q, acq_len_d;
    logic [ACQ_W-1:0]  wcnt_q, wcnt_d;
    logic [1:0]        phase_q, phase_d;
    logic              acq_valid_q, acq_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              tbl_we;
    logic [1:0]        tbl_rdata;
    logic [TBL_AW:0]   idx_inc;

    assign tbl_we  = cfg_we && (state_q == ST_IDLE);
    assign idx_inc = {1'b0, idx_q} + LEN_ONE;

    rx_phase_table #(
        .TBL_DEPTH (TBL_DEPTH),
        .TBL_AW    (TBL_AW)
    ) u_tbl (
        .clk     (clk),
        .rst     (rst),
        .we_i    (tbl_we),
        .waddr_i (cfg_addr),
        .wdata_i (cfg_phase),
        .raddr_i (idx_d),
        .rdata_o (tbl_rdata)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tbl_len_d = tbl_len_q;
        n_scans_d = n_scans_q;
        scan_d    = scan_q;
        acq_len_d = acq_len_q;
        wcnt_d    = wcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_tbl_len == '0) begin
                        tbl_len_d = LEN_ONE;
                    end else if (cfg_tbl_len > LEN_MAX) begin
                        tbl_len_d = LEN_MAX;
                    end else begin
                        tbl_len_d = cfg_tbl_len;
                    end
                    n_scans_d = cfg_n_scans;
                    acq_len_d = (cfg_acq_len == '0) ? ACQ_ONE : cfg_acq_len;
                    idx_d     = '0;
                    scan_d    = '0;
                    state_d   = (cfg_n_scans == '0) ? ST_FIN : ST_ARM;
                end
            end
            ST_ARM: begin
                if (trig) begin
                    wcnt_d  = acq_len_q;
                    state_d = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (wcnt_q == ACQ_ONE) begin
                    state_d = ST_NEXT;
                end else begin
                    wcnt_d = wcnt_q - ACQ_ONE;
                end
            end
            ST_NEXT: begin
                scan_d  = scan_q + SCAN_ONE;
                idx_d   = (idx_inc == tbl_len_q) ? '0 : idx_q + IDX_ONE;
                state_d = (scan_q + SCAN_ONE == n_scans_q) ? ST_FIN : ST_ARM;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort only redirects the state; counters keep what was already completed.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        acq_valid_d = (state_d == ST_ACQ);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_q == ST_FIN) && !abort;
        err_d       = trig && !abort && ((state_q == ST_ACQ) || (state_q == ST_NEXT));
    end

    // Phase only updates while armed, so it is frozen across the whole window.
    assign phase_d = (state_d == ST_ARM) ? tbl_rdata : phase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tbl_len_q   <= LEN_ONE;
            n_scans_q   <= '0;
            scan_q      <= '0;
            acq_len_q   <= ACQ_ONE;
            wcnt_q      <= '0;
            phase_q     <= PH_0;
            acq_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tbl_len_q   <= tbl_len_d;
            n_scans_q   <= n_scans_d;
            scan_q      <= scan_d;
            acq_len_q   <= acq_len_d;
            wcnt_q      <= wcnt_d;
            phase_q     <= phase_d;
            acq_valid_q <= acq_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign phase      = phase_q;
    assign acq_valid  = acq_valid_q;
    assign scan_count = scan_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_trig   = err_q;

endmodule

// File: tb/tb_rx_phase_cycler.sv
// tb/tb_rx_phase_cycler.sv - randomized scan-level checks of rx_phase_cycler against a per-scan model.
module tb_rx_phase_cycler;
    import rx_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int SW    = 16;
    localparam int QW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [1:0]    cfg_phase = '0;
    logic [AW:0]   cfg_tbl_len = '0;
    logic [SW-1:0] cfg_n_scans = '0;
    logic [QW-1:0] cfg_acq_len = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          trig = 1'b0;
    logic [1:0]    phase;
    logic          acq_valid;
    logic [SW-1:0] scan_count;
    logic          busy;
    logic          done;
    logic          err_trig;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] model_tbl [DEPTH];

    int         done_cnt = 0;
    int         err_cnt = 0;
    bit         in_win = 0;
    bit         win_stable = 0;
    bit         busy_prev = 0;
    bit         done_busy_ok = 0;
    int         win_len = 0;
    logic [1:0] win_ph = '0;
    int         q_len [$];
    logic [1:0] q_ph [$];
    bit         q_ok [$];

    rx_phase_cycler #(
        .TBL_DEPTH (DEPTH),
        .TBL_AW    (AW),
        .SCAN_W    (SW),
        .ACQ_W     (QW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_phase   (cfg_phase),
        .cfg_tbl_len (cfg_tbl_len),
        .cfg_n_scans (cfg_n_scans),
        .cfg_acq_len (cfg_acq_len),
        .start       (start),
        .abort       (abort),
        .trig        (trig),
        .phase       (phase),
        .acq_valid   (acq_valid),
        .scan_count  (scan_count),
        .busy        (busy),
        .done        (done),
        .err_trig    (err_trig)
    );

    always #5 clk = ~clk;

    // Window recorder: one entry per contiguous acq_valid run.
    always @(negedge clk) begin
        if (acq_valid) begin
            if (!in_win) begin
                in_win     = 1;
                win_len    = 0;
                win_ph     = phase;
                win_stable = 1;
            end
            win_len++;
            if (phase != win_ph) win_stable = 0;
        end else if (in_win) begin
            in_win = 0;
            q_len.push_back(win_len);
            q_ph.push_back(win_ph);
            q_ok.push_back(win_stable);
        end
        if (done) begin
            done_cnt++;
            done_busy_ok = !busy && busy_prev;
        end
        if (err_trig) err_cnt++;
        busy_prev = busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        done_cnt     = 0;
        err_cnt      = 0;
        done_busy_ok = 0;
        q_len.delete();
        q_ph.delete();
        q_ok.delete();
    endtask

    task automatic wr_tbl(input int a, input logic [1:0] p);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_phase = p;
        @(negedge clk);
        cfg_we = 1'b0;
        model_tbl[a] = p;
    endtask

    function automatic int eff_len(input int tl);
        if (tl == 0) return 1;
        if (tl > DEPTH) return DEPTH;
        return tl;
    endfunction

    task automatic run_scans(input string tag, input int tl, input int ns, input int al,
                             input int gap_fix, input int dbl_scan, input int kill_scan,
                             input bit kill_rst, input bit busy_wr);
        int         el, ea, gap, used, exp_sc, n_win, t;
        bit         killed;
        logic [1:0] exp_ph [$];
        el     = eff_len(tl);
        ea     = (al == 0) ? 1 : al;
        exp_sc = ns;
        killed = 0;
        for (int k = 0; k < ns; k++) exp_ph.push_back(model_tbl[k % el]);
        clear_mon();
        cfg_tbl_len = (AW+1)'(tl);
        cfg_n_scans = SW'(ns);
        cfg_acq_len = QW'(al);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy"}, busy, 1);
        for (int k = 0; k < ns; k++) begin
            gap = (gap_fix > 0) ? gap_fix : ea + 2 + int'($urandom_range(0, 4));
            chk($sformatf("%s phase%0d", tag, k), phase, exp_ph[k]);
            trig = 1'b1;
            @(negedge clk);
            trig = 1'b0;
            used = 1;
            chk($sformatf("%s lat%0d", tag, k), acq_valid, 1);
            if (k == dbl_scan) begin
                @(negedge clk);
                trig = 1'b1;
                @(negedge clk);
                trig = 1'b0;
                used = 3;
            end
            if (k == kill_scan) begin
                @(negedge clk);
                if (kill_rst) rst = 1'b1;
                else abort = 1'b1;
                @(negedge clk);
                rst   = 1'b0;
                abort = 1'b0;
                chk({tag, " kill acq_valid"}, acq_valid, 0);
                chk({tag, " kill busy"}, busy, 0);
                chk({tag, " kill done"}, done, 0);
                chk({tag, " kill err"}, err_trig, 0);
                if (kill_rst) begin
                    chk({tag, " rst phase"}, phase, 0);
                    chk({tag, " rst scans"}, scan_count, 0);
                    exp_sc = 0;
                    for (int i = 0; i < DEPTH; i++) model_tbl[i] = PH_0;
                end else begin
                    chk({tag, " abort phase"}, phase, exp_ph[k]);
                    chk({tag, " abort scans"}, scan_count, k);
                    exp_sc = k;
                end
                killed = 1;
                break;
            end
            if (busy_wr && k == 0) begin
                cfg_we    = 1'b1;
                cfg_addr  = AW'(1 % el);
                cfg_phase = ~model_tbl[1 % el];
                @(negedge clk);
                cfg_we = 1'b0;
                used++;
            end
            if (gap > used) repeat (gap - used) @(negedge clk);
        end
        if (!killed) begin
            t = 0;
            while (done_cnt == 0 && t < 64) begin
                @(negedge clk);
                t++;
            end
            chk({tag, " done seen"}, (done_cnt > 0), 1);
        end
        repeat (4) @(negedge clk);
        chk({tag, " scan_count"}, scan_count, exp_sc);
        chk({tag, " done pulses"}, done_cnt, killed ? 0 : 1);
        if (!killed) chk({tag, " busy falls with done"}, done_busy_ok, 1);
        chk({tag, " err pulses"}, err_cnt, (dbl_scan >= 0 && dbl_scan < ns) ? 1 : 0);
        n_win = killed ? kill_scan + 1 : ns;
        chk({tag, " windows"}, q_len.size(), n_win);
        for (int k = 0; k < n_win && k < q_len.size(); k++) begin
            chk($sformatf("%s win%0d len", tag, k), q_len[k], (killed && k == kill_scan) ? 2 : ea);
            chk($sformatf("%s win%0d phase", tag, k), q_ph[k], exp_ph[k]);
            chk($sformatf("%s win%0d frozen", tag, k), q_ok[k], 1);
        end
        chk({tag, " idle busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model_tbl[i] = PH_0;
        repeat (3) @(negedge clk);
        chk("reset phase", phase, 0);
        chk("reset acq_valid", acq_valid, 0);
        chk("reset scan_count", scan_count, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err_trig", err_trig, 0);
        rst = 1'b0;
        @(negedge clk);

        run_scans("tbl_reset", 8, 3, 1, 0, -1, -1, 0, 0);

        wr_tbl(0, PH_0);
        wr_tbl(1, PH_90);
        wr_tbl(2, PH_180);
        wr_tbl(3, PH_270);
        run_scans("cyclops", 4, 6, 4, 20, -1, -1, 0, 0);

        clear_mon();
        cfg_n_scans = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ns0 done early", done, 0);
        @(negedge clk);
        chk("ns0 done", done, 1);
        @(negedge clk);
        chk("ns0 done width", done, 0);
        repeat (3) @(negedge clk);
        chk("ns0 scan_count", scan_count, 0);
        chk("ns0 windows", q_len.size(), 0);
        chk("ns0 done pulses", done_cnt, 1);

        run_scans("acq0", 4, 3, 0, 0, -1, -1, 0, 0);

        for (int i = 0; i < DEPTH; i++) wr_tbl(i, 2'($urandom_range(0, 3)));
        run_scans("tbl0", 0, 4, 2, 0, -1, -1, 0, 0);

        run_scans("dbl", 4, 3, 4, 0, 1, -1, 0, 0);

        run_scans("abort", 4, 5, 5, 0, -1, 2, 0, 0);
        run_scans("post_abort", 4, 5, 5, 0, -1, -1, 0, 0);

        run_scans("busy_wr", 4, 4, 2, 0, -1, -1, 0, 1);
        run_scans("after_busy_wr", 4, 4, 2, 0, -1, -1, 0, 0);

        wr_tbl(0, PH_180);
        wr_tbl(1, PH_270);
        wr_tbl(2, PH_90);
        run_scans("wrap", 3, 7, 3, 0, -1, -1, 0, 0);

        for (int i = 0; i < DEPTH; i++) wr_tbl(i, 2'($urandom_range(0, 3)));
        run_scans("clamp", 12, 10, 1, 0, -1, -1, 0, 0);

        for (int i = 0; i < DEPTH; i++) wr_tbl(i, 2'($urandom_range(1, 3)));
        run_scans("rst", 4, 4, 5, 0, -1, 1, 1, 0);
        run_scans("post_rst", 4, 3, 2, 0, -1, -1, 0, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) wr_tbl(i, 2'($urandom_range(0, 3)));
            run_scans($sformatf("rand%0d", r), int'($urandom_range(0, 10)),
                      int'($urandom_range(1, 6)), int'($urandom_range(0, 5)),
                      0, -1, -1, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
